// File: rtl/hv_chunk_assembler.sv
`default_nettype none
// =============================================================================
// Module   : hv_chunk_assembler
// Brief    : Collects CHUNK_WIDTH-bit beats into a HV_DIMENSION-bit hypervector
//            (chunk 0 lands in the lowest indices) and presents it through a
//            double-buffered valid/ready output with sticky framing-error flag.
//            Optional macro HV_ASM_BYPASS_EN: load the output register on the
//            last-chunk edge whenever it is free.
// Revision : 1.0  initial release
// =============================================================================
module hv_chunk_assembler #(
   parameter int HV_DIMENSION = 2048,
   parameter int CHUNK_WIDTH  = 256
) (
   input  logic                    Clk_CI,
   input  logic                    Reset_RI,
   input  logic [0:CHUNK_WIDTH-1]  ChunkIn_DI,
   input  logic                    ValidIn_SI,
   input  logic                    LastIn_SI,
   output logic                    ReadyOut_SO,
   output logic [0:HV_DIMENSION-1] HypervectorOut_DO,
   output logic                    ValidOut_SO,
   input  logic                    ReadyIn_SI,
   output logic                    FrameErr_SO,
   input  logic                    FrameErrClr_SI
);

   localparam int NUM_CHUNKS = HV_DIMENSION / CHUNK_WIDTH;
   localparam int CNT_WIDTH  = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
   localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(NUM_CHUNKS - 1);

   typedef enum logic [0:0] {
      FILL = 1'b0,
      FULL = 1'b1
   } state_t;

   state_t                  state_q, state_d;
   logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
   logic [0:HV_DIMENSION-1] asm_hv_q, asm_hv_d;
   logic [0:HV_DIMENSION-1] out_hv_q, out_hv_d;
   logic                    out_valid_q, out_valid_d;
   logic                    frame_err_q, frame_err_d;

   logic                    w_in_xfer;
   logic                    w_out_xfer;
   logic                    w_out_free;
   logic                    w_at_last;
   logic                    w_good_last;
   logic                    w_frame_bad;
   logic                    w_chunk_wr;
   logic [NUM_CHUNKS-1:0]   w_slot_wr;
   logic [0:HV_DIMENSION-1] w_asm_next;

   // Ready is forced low while reset is held, independent of the state flop.
   assign ReadyOut_SO = (state_q == FILL) && !Reset_RI;

   assign w_in_xfer   = ValidIn_SI && ReadyOut_SO;
   assign w_out_xfer  = out_valid_q && ReadyIn_SI;
   assign w_out_free  = !out_valid_q || w_out_xfer;
   assign w_at_last   = (cnt_q == LAST_IDX);
   assign w_good_last = w_in_xfer && w_at_last && LastIn_SI;
   assign w_frame_bad = w_in_xfer && (w_at_last != LastIn_SI);
   assign w_chunk_wr  = w_in_xfer && !w_frame_bad;

   // Assembly image with the current beat merged into its slot.
   generate
      for (genvar k = 0; k < NUM_CHUNKS; k++) begin : g_chunk_slot
         assign w_slot_wr[k] = w_chunk_wr && (cnt_q == CNT_WIDTH'(k));
         assign w_asm_next[k*CHUNK_WIDTH +: CHUNK_WIDTH] =
            w_slot_wr[k] ? ChunkIn_DI : asm_hv_q[k*CHUNK_WIDTH +: CHUNK_WIDTH];
      end
   endgenerate

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      asm_hv_d    = asm_hv_q;
      out_hv_d    = out_hv_q;
      out_valid_d = out_valid_q && !w_out_xfer;
      frame_err_d = w_frame_bad || (frame_err_q && !FrameErrClr_SI);

      case (state_q)
         FILL: begin
            if (w_frame_bad) begin
               cnt_d = '0;
            end else if (w_good_last) begin
               cnt_d    = '0;
               asm_hv_d = w_asm_next;
`ifdef HV_ASM_BYPASS_EN
               if (w_out_free) begin
                  out_hv_d    = w_asm_next;
                  out_valid_d = 1'b1;
               end else begin
                  state_d = FULL;
               end
`else
               state_d = FULL;
`endif
            end else if (w_chunk_wr) begin
               cnt_d    = cnt_q + CNT_WIDTH'(1);
               asm_hv_d = w_asm_next;
            end
         end
         FULL: begin
            if (w_out_free) begin
               out_hv_d    = asm_hv_q;
               out_valid_d = 1'b1;
               state_d     = FILL;
            end
         end
         default: begin
            state_d = FILL;
         end
      endcase
   end

   always_ff @(posedge Clk_CI or posedge Reset_RI) begin
      if (Reset_RI) begin
         state_q     <= FILL;
         cnt_q       <= '0;
         asm_hv_q    <= '0;
         out_hv_q    <= '0;
         out_valid_q <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         asm_hv_q    <= asm_hv_d;
         out_hv_q    <= out_hv_d;
         out_valid_q <= out_valid_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign HypervectorOut_DO = out_hv_q;
   assign ValidOut_SO       = out_valid_q;
   assign FrameErr_SO       = frame_err_q;

endmodule
`default_nettype wire
